// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the PC source unit.
//   pc_state_e  : exception-entry FSM state
//   SRC_*       : canonical source indices on the flattened source bus
//   pc_ctl_t    : write-control bundle sampled each cycle in RUN
//   pc_wr_en()  : combined unconditional / branch-conditional write enable
package pc_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EXC_SAVE = 2'd1,
    EXC_JUMP = 2'd2
  } pc_state_e;

  localparam int SRC_REGA   = 0;
  localparam int SRC_ALU    = 1;
  localparam int SRC_JUMP   = 2;
  localparam int SRC_ALUOUT = 3;
  localparam int SRC_EPC    = 4;
  localparam int SRC_EXC    = 5;

  localparam int DEF_INSTR_BYTES = 4;

  typedef struct packed {
    logic pc_write;
    logic pc_write_cond;
    logic cond_met;
  } pc_ctl_t;

  // Both write flavours OR together into a single write.
  function automatic logic pc_wr_en(input pc_ctl_t c);
    return c.pc_write | (c.pc_write_cond & c.cond_met);
  endfunction

endpackage

// File: rtl/pc_src_mux.sv
// pc_src_mux: combinational NUM_SRC:1 selector over a flattened source bus.
//   src_data : NUM_SRC*WIDTH, source i at [i*WIDTH +: WIDTH]
//   sel      : source select
//   dout     : selected source (zero when sel is out of range)
//   illegal  : sel >= NUM_SRC
module pc_src_mux #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 6,
  parameter int SEL_W   = 3
) (
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         sel,
  output logic [WIDTH-1:0]         dout,
  output logic                     illegal
);

  logic [NUM_SRC-1:0][WIDTH-1:0] src;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign src[g] = src_data[g*WIDTH +: WIDTH];
  end

  // Compare-based select so select codes beyond NUM_SRC never index
  // past the array; they fall through to the illegal default.
  always_comb begin
    dout    = '0;
    illegal = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        dout    = src[i];
        illegal = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: next-PC selection, PC register and exception entry.
//   clk, reset     : clock, synchronous active-high reset
//   src_data       : flattened PC source candidates
//   pc_source      : source select for normal writes
//   pc_write       : unconditional write
//   pc_write_cond  : branch write, qualified by cond_met
//   exc_req        : exception request pulse
//   pc_out/epc_out : current PC / saved exception PC
//   busy           : exception entry in progress
//   sel_err        : sticky illegal-select flag
//   pc_loaded      : pulse, PC was written at the previous edge
// Note: 2**SEL_W must cover NUM_SRC.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int                 WIDTH       = 32,
  parameter int                 NUM_SRC     = 6,
  parameter int                 SEL_W       = 3,
  parameter logic [WIDTH-1:0]   RESET_PC    = '0,
  parameter int                 EXC_SRC     = SRC_EXC,
  parameter int                 INSTR_BYTES = DEF_INSTR_BYTES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         pc_source,
  input  logic                     pc_write,
  input  logic                     pc_write_cond,
  input  logic                     cond_met,
  input  logic                     exc_req,
  output logic [WIDTH-1:0]         pc_out,
  output logic [WIDTH-1:0]         epc_out,
  output logic                     busy,
  output logic                     sel_err,
  output logic                     pc_loaded
);

  pc_state_e        state;
  pc_ctl_t          ctl;
  logic [WIDTH-1:0] sel_pc;
  logic             sel_bad;
  logic [WIDTH-1:0] exc_vec;
  logic             wr_en;

  assign ctl     = '{pc_write: pc_write, pc_write_cond: pc_write_cond, cond_met: cond_met};
  assign wr_en   = pc_wr_en(ctl);
  assign exc_vec = src_data[EXC_SRC*WIDTH +: WIDTH];

  pc_src_mux #(
    .WIDTH  (WIDTH),
    .NUM_SRC(NUM_SRC),
    .SEL_W  (SEL_W)
  ) u_mux (
    .src_data(src_data),
    .sel     (pc_source),
    .dout    (sel_pc),
    .illegal (sel_bad)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      pc_out    <= RESET_PC;
      epc_out   <= '0;
      busy      <= 1'b0;
      sel_err   <= 1'b0;
      pc_loaded <= 1'b0;
    end else begin
      pc_loaded <= 1'b0;
      case (state)
        RUN: begin
          // Exception outranks any write in the same cycle; the write is lost.
          if (exc_req) begin
            state <= EXC_SAVE;
            busy  <= 1'b1;
          end else if (wr_en) begin
            if (sel_bad) begin
              sel_err <= 1'b1;
            end else begin
              pc_out    <= sel_pc;
              pc_loaded <= 1'b1;
            end
          end
        end
        EXC_SAVE: begin
          // Wraps modulo 2**WIDTH.
          epc_out <= pc_out - WIDTH'(INSTR_BYTES);
          state   <= EXC_JUMP;
        end
        EXC_JUMP: begin
          // Vector is sampled here, not at the request edge.
          pc_out    <= exc_vec;
          pc_loaded <= 1'b1;
          busy      <= 1'b0;
          state     <= RUN;
        end
        default: begin
          state <= RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;
  localparam int WIDTH = 32;
  localparam int NSRC  = 6;
  localparam int SELW  = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NSRC-1:0][WIDTH-1:0] srcs;
  logic [NSRC*WIDTH-1:0] src_data;
  logic [SELW-1:0]       pc_source;
  logic                  pc_write, pc_write_cond, cond_met, exc_req;
  logic [WIDTH-1:0]      pc_out, epc_out;
  logic                  busy, sel_err, pc_loaded;

  int pass_cnt = 0;
  int total    = 0;

  assign src_data = srcs;

  always #5 clk = ~clk;

  pc_next_unit #(.WIDTH(WIDTH), .NUM_SRC(NSRC), .SEL_W(SELW)) dut (
    .clk(clk), .reset(reset), .src_data(src_data), .pc_source(pc_source),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond_met(cond_met),
    .exc_req(exc_req), .pc_out(pc_out), .epc_out(epc_out), .busy(busy),
    .sel_err(sel_err), .pc_loaded(pc_loaded)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc_write = 0; pc_write_cond = 0; cond_met = 0; exc_req = 0; pc_source = '0;
  endtask

  task automatic test_reset();
    reset = 1; idle();
    tick(); tick();
    reset = 0;
    total++; if (pc_out !== 32'h0) $display("FAIL rst_pc got %h want %h", pc_out, 32'h0); else pass_cnt++;
    total++; if (epc_out !== 32'h0) $display("FAIL rst_epc got %h want %h", epc_out, 32'h0); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_cnt++;
    total++; if (sel_err !== 1'b0) $display("FAIL rst_sel_err got %b want 0", sel_err); else pass_cnt++;
    total++; if (pc_loaded !== 1'b0) $display("FAIL rst_loaded got %b want 0", pc_loaded); else pass_cnt++;
  endtask

  task automatic test_uncond();
    srcs[1] = 32'h40; pc_source = 3'd1; pc_write = 1;
    tick(); idle();
    total++; if (pc_out !== 32'h40) $display("FAIL uncond_pc got %h want %h", pc_out, 32'h40); else pass_cnt++;
    total++; if (pc_loaded !== 1'b1) $display("FAIL uncond_loaded got %b want 1", pc_loaded); else pass_cnt++;
    tick();
    total++; if (pc_loaded !== 1'b0) $display("FAIL uncond_pulse_end got %b want 0", pc_loaded); else pass_cnt++;
    total++; if (pc_out !== 32'h40) $display("FAIL uncond_hold got %h want %h", pc_out, 32'h40); else pass_cnt++;
  endtask

  task automatic test_cond();
    srcs[3] = 32'h100; pc_source = 3'd3; pc_write_cond = 1; cond_met = 0;
    tick();
    total++; if (pc_out !== 32'h40) $display("FAIL cond0_pc got %h want %h", pc_out, 32'h40); else pass_cnt++;
    total++; if (pc_loaded !== 1'b0) $display("FAIL cond0_loaded got %b want 0", pc_loaded); else pass_cnt++;
    cond_met = 1;
    tick(); idle();
    total++; if (pc_out !== 32'h100) $display("FAIL cond1_pc got %h want %h", pc_out, 32'h100); else pass_cnt++;
    total++; if (pc_loaded !== 1'b1) $display("FAIL cond1_loaded got %b want 1", pc_loaded); else pass_cnt++;
    // both write strobes, condition false: unconditional still writes once
    srcs[0] = 32'h200; pc_source = 3'd0; pc_write = 1; pc_write_cond = 1; cond_met = 0;
    tick(); idle();
    total++; if (pc_out !== 32'h200) $display("FAIL or_pc got %h want %h", pc_out, 32'h200); else pass_cnt++;
  endtask

  task automatic test_exception();
    srcs[2] = 32'h999; srcs[5] = 32'h1234;
    pc_source = 3'd2; pc_write = 1; exc_req = 1;
    tick();                       // edge n
    exc_req = 1;                  // must be ignored while busy
    srcs[5] = 32'h8000_0180;      // vector sampled later, at edge n+2
    total++; if (pc_out !== 32'h200) $display("FAIL exc_drop_pc got %h want %h", pc_out, 32'h200); else pass_cnt++;
    total++; if (busy !== 1'b1) $display("FAIL exc_busy1 got %b want 1", busy); else pass_cnt++;
    total++; if (pc_loaded !== 1'b0) $display("FAIL exc_loaded0 got %b want 0", pc_loaded); else pass_cnt++;
    tick();                       // edge n+1
    idle();
    total++; if (epc_out !== 32'h1FC) $display("FAIL exc_epc got %h want %h", epc_out, 32'h1FC); else pass_cnt++;
    total++; if (busy !== 1'b1) $display("FAIL exc_busy2 got %b want 1", busy); else pass_cnt++;
    total++; if (pc_out !== 32'h200) $display("FAIL exc_save_pc got %h want %h", pc_out, 32'h200); else pass_cnt++;
    tick();                       // edge n+2
    total++; if (pc_out !== 32'h8000_0180) $display("FAIL exc_vec_pc got %h want %h", pc_out, 32'h8000_0180); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL exc_busy_end got %b want 0", busy); else pass_cnt++;
    total++; if (pc_loaded !== 1'b1) $display("FAIL exc_loaded got %b want 1", pc_loaded); else pass_cnt++;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL exc_no_reentry got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_exc_src_normal();
    srcs[5] = 32'h500; pc_source = 3'd5; pc_write = 1;
    tick(); idle();
    total++; if (pc_out !== 32'h500) $display("FAIL src5_pc got %h want %h", pc_out, 32'h500); else pass_cnt++;
    total++; if (epc_out !== 32'h1FC) $display("FAIL src5_epc got %h want %h", epc_out, 32'h1FC); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL src5_busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_sel_err();
    pc_source = 3'd7; pc_write = 1;
    tick(); idle();
    total++; if (pc_out !== 32'h500) $display("FAIL selerr_pc got %h want %h", pc_out, 32'h500); else pass_cnt++;
    total++; if (sel_err !== 1'b1) $display("FAIL selerr_set got %b want 1", sel_err); else pass_cnt++;
    total++; if (pc_loaded !== 1'b0) $display("FAIL selerr_loaded got %b want 0", pc_loaded); else pass_cnt++;
    srcs[1] = 32'h44; pc_source = 3'd1; pc_write = 1;
    tick(); idle();
    total++; if (pc_out !== 32'h44) $display("FAIL selerr_legal_pc got %h want %h", pc_out, 32'h44); else pass_cnt++;
    total++; if (sel_err !== 1'b1) $display("FAIL selerr_sticky got %b want 1", sel_err); else pass_cnt++;
  endtask

  task automatic test_wrap();
    reset = 1; tick(); reset = 0;
    total++; if (sel_err !== 1'b0) $display("FAIL selerr_clr got %b want 0", sel_err); else pass_cnt++;
    // illegal write alongside exc_req: exception wins, no sel_err
    srcs[5] = 32'hABC0; pc_source = 3'd7; pc_write = 1; exc_req = 1;
    tick(); idle();
    total++; if (sel_err !== 1'b0) $display("FAIL exc_vs_selerr got %b want 0", sel_err); else pass_cnt++;
    tick();
    total++; if (epc_out !== 32'hFFFF_FFFC) $display("FAIL wrap_epc got %h want %h", epc_out, 32'hFFFF_FFFC); else pass_cnt++;
    tick();
    total++; if (pc_out !== 32'hABC0) $display("FAIL wrap_pc got %h want %h", pc_out, 32'hABC0); else pass_cnt++;
  endtask

  task automatic test_reset_mid_exc();
    exc_req = 1;
    tick(); idle();               // now in EXC_SAVE
    total++; if (busy !== 1'b1) $display("FAIL mid_busy got %b want 1", busy); else pass_cnt++;
    reset = 1;
    tick(); reset = 0;
    total++; if (pc_out !== 32'h0) $display("FAIL mid_pc got %h want %h", pc_out, 32'h0); else pass_cnt++;
    total++; if (epc_out !== 32'h0) $display("FAIL mid_epc got %h want %h", epc_out, 32'h0); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL mid_busy_clr got %b want 0", busy); else pass_cnt++;
    srcs[1] = 32'h40; pc_source = 3'd1; pc_write = 1;
    tick(); idle();
    total++; if (pc_out !== 32'h40) $display("FAIL mid_write_pc got %h want %h", pc_out, 32'h40); else pass_cnt++;
    total++; if (pc_loaded !== 1'b1) $display("FAIL mid_write_loaded got %b want 1", pc_loaded); else pass_cnt++;
    tick();
    total++; if (pc_out !== 32'h40) $display("FAIL mid_hold_pc got %h want %h", pc_out, 32'h40); else pass_cnt++;
  endtask

  initial begin
    srcs = '0;
    test_reset();
    test_uncond();
    test_cond();
    test_exception();
    test_exc_src_normal();
    test_sel_err();
    test_wrap();
    test_reset_mid_exc();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
